// File: rtl/prio_dec1_2to4_pkg.sv
// prio_dec1_2to4_pkg: shared line count, code width and default counter width
package prio_dec1_2to4_pkg;
    localparam int N_LINES   = 4;
    localparam int CODE_W    = 2;
    localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/prio_dec1_2to4_dec_line_ctr.sv
// dec_line_ctr: one line's sticky pending bit, saturating event counter and overflow flag
module dec_line_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ev,
    input  logic             i_clr,
    output logic             o_pend,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf
);
    logic w_sat;
    assign w_sat = &o_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            o_pend <= 1'b0;
            o_cnt  <= '0;
            o_ovf  <= 1'b0;
        end else if (i_ev) begin
            o_pend <= 1'b1;
            o_cnt  <= i_clr ? CNT_W'(1) : (w_sat ? o_cnt : o_cnt + 1'b1);
            o_ovf  <= i_clr ? 1'b0 : (o_ovf | w_sat);
        end else if (i_clr) begin
            o_pend <= 1'b0;
            o_cnt  <= '0;
            o_ovf  <= 1'b0;
        end
    end
endmodule

// File: rtl/prio_dec1_2to4.sv
// prio_dec1_2to4: registered 2-to-4 decode with per-line pending, saturating counters and clear handshake
module prio_dec1_2to4
    import prio_dec1_2to4_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CODE_W-1:0]        code,
    input  logic                     code_v,
    output logic [N_LINES-1:0]       onehot,
    output logic                     onehot_v,
    output logic [N_LINES-1:0]       pend,
    input  logic [N_LINES-1:0]       clr_mask,
    input  logic                     clr_req,
    output logic                     clr_ack,
    output logic [N_LINES*CNT_W-1:0] cnt,
    output logic [N_LINES-1:0]       ovf
);
    logic [N_LINES-1:0] w_ev;
    logic [N_LINES-1:0] w_clr;
    assign w_ev  = code_v ? N_LINES'(1) << code : '0;
    assign w_clr = clr_req ? clr_mask : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            onehot   <= '0;
            onehot_v <= 1'b0;
            clr_ack  <= 1'b0;
        end else begin
            onehot   <= w_ev;
            onehot_v <= code_v;
            clr_ack  <= clr_req;
        end
    end
    for (genvar i = 0; i < N_LINES; i++) begin : g_line
        dec_line_ctr #(.CNT_W(CNT_W)) u_line (
            .clk    (clk),
            .rst    (rst),
            .i_ev   (w_ev[i]),
            .i_clr  (w_clr[i]),
            .o_pend (pend[i]),
            .o_cnt  (cnt[i*CNT_W +: CNT_W]),
            .o_ovf  (ovf[i])
        );
    end
endmodule

// File: tb/tb_prio_dec1_2to4.sv
// tb_prio_dec1_2to4: directed and random checks of prio_dec1_2to4 against a behavioural line model
module tb_prio_dec1_2to4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    code = '0;
    logic          code_v = 1'b0;
    logic [3:0]    onehot;
    logic          onehot_v;
    logic [3:0]    pend;
    logic [3:0]    clr_mask = '0;
    logic          clr_req = 1'b0;
    logic          clr_ack;
    logic [4*CW-1:0] cnt;
    logic [3:0]    ovf;
    int n_cmp = 0;
    int n_err = 0;
    int m_cnt [4];
    bit m_pend [4];
    bit m_ovf [4];
    logic [3:0] m_oh;
    bit m_ohv;
    bit m_ack;

    prio_dec1_2to4 #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .code(code), .code_v(code_v),
        .onehot(onehot), .onehot_v(onehot_v), .pend(pend),
        .clr_mask(clr_mask), .clr_req(clr_req), .clr_ack(clr_ack),
        .cnt(cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [4*CW-1:0] e_cnt;
        logic [3:0] e_pend, e_ovf;
        for (int i = 0; i < 4; i++) begin
            e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
            e_pend[i] = m_pend[i];
            e_ovf[i]  = m_ovf[i];
        end
        chk("onehot", 32'(onehot), 32'(m_oh));
        chk("onehot_v", 32'(onehot_v), 32'(m_ohv));
        chk("pend", 32'(pend), 32'(e_pend));
        chk("cnt", 32'(cnt), 32'(e_cnt));
        chk("ovf", 32'(ovf), 32'(e_ovf));
        chk("clr_ack", 32'(clr_ack), 32'(m_ack));
    endtask

    task automatic step(input logic r, input logic cv, input logic [1:0] c,
                        input logic [3:0] cm, input logic cr);
        rst = r; code_v = cv; code = cv ? c : 2'bxx; clr_mask = cm; clr_req = cr;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
            end
            m_oh = 4'd0; m_ohv = 0; m_ack = 0;
        end else begin
            m_oh  = cv ? 4'(2 ** int'(c)) : 4'd0;
            m_ohv = cv;
            m_ack = cr;
            for (int i = 0; i < 4; i++) begin
                bit ev, cl;
                ev = cv && (int'(c) == i);
                cl = cr && cm[i];
                if (ev) begin
                    m_pend[i] = 1;
                    if (cl) begin
                        m_cnt[i] = 1; m_ovf[i] = 0;
                    end else if (m_cnt[i] == MAXC) m_ovf[i] = 1;
                    else m_cnt[i] = m_cnt[i] + 1;
                end else if (cl) begin
                    m_pend[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
                end
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        step(1, 1, 2, 4'd0, 0);
        step(1, 1, 2, 4'd0, 0);
        step(0, 0, 0, 4'd0, 0);
        chk("reset_release_onehot", 32'(onehot), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 2'(i), 4'd0, 0);
            chk("stream_onehot", 32'(onehot), 32'(4'd1 << i));
        end
        chk("stream_pend", 32'(pend), 32'hf);
        chk("stream_cnt", 32'(cnt), 32'h1111);
        step(0, 0, 0, 4'b0101, 1);
        chk("clear_pend", 32'(pend), 32'ha);
        chk("clear_ack", 32'(clr_ack), 32'd1);
        step(0, 0, 0, 4'b0000, 1);
        step(0, 0, 0, 4'b0000, 1);
        step(0, 0, 0, 4'd0, 0);
        step(1, 0, 0, 4'd0, 0);
        for (int i = 0; i < 17; i++) step(0, 1, 2, 4'd0, 0);
        chk("sat_cnt", 32'(cnt), 32'h0f00);
        chk("sat_ovf", 32'(ovf), 32'h4);
        step(0, 1, 2, 4'b0100, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 4'd0, 0);
        step(0, 1, 1, 4'b0010, 1);
        chk("collide_cnt1", 32'(cnt[CW +: CW]), 32'd1);
        step(0, 1, 3, 4'b0001, 1);
        step(0, 1, 0, 4'd0, 0);
        step(0, 1, 1, 4'd0, 0);
        step(1, 1, 2, 4'd0, 0);
        step(0, 0, 0, 4'd0, 0);
        chk("midrst_no_stale", 32'(onehot_v), 32'd0);
        step(0, 1, 3, 4'd0, 0);
        chk("midrst_onehot", 32'(onehot), 32'h8);
        for (int n = 0; n < 500; n++)
            step(($urandom % 50) == 0, ($urandom % 4) != 0, 2'($urandom),
                 4'($urandom), ($urandom % 20) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/prio_dec1_2to4.md
PRIO_DEC1_2TO4 -- requirements
Module: prio_dec1_2to4

Interface
REQ-001 Parameter CNT_W, default 4: width of each per-line event counter; legal range 2..8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 code  input  2  encoded line index, 0..3, from the upstream 4-to-2 priority encoder.
REQ-005 code_v  input  1  code valid; code is sampled only when code_v=1.
REQ-006 onehot  output reg  4  registered one-hot decode of the last accepted code; zero when no code was accepted.
REQ-007 onehot_v  output reg  1  high for one cycle per accepted code.
REQ-008 pend  output reg  4  sticky per-line pending mask.
REQ-009 clr_mask  input  4  lines to clear; sampled only with clr_req.
REQ-010 clr_req  input  1  clear request strobe.
REQ-011 clr_ack  output reg  1  one-cycle acknowledge of a clear.
REQ-012 cnt  output reg  4*CNT_W  packed per-line event counters; line i at bits [i*CNT_W +: CNT_W].
REQ-013 ovf  output reg  4  sticky per-line counter-saturation flag.

Function
REQ-014 Accept: a cycle with code_v=1 is an accepted event for line code.
REQ-015 Decode latency: onehot=1<<code and onehot_v=1 in the cycle after acceptance.
REQ-016 Idle: onehot=4'b0000 and onehot_v=0 in the cycle after any cycle with code_v=0.
REQ-017 Back-to-back: consecutive accepted codes each produce their own onehot in consecutive cycles; there is no bubble.
REQ-018 Pending: an accepted event sets pend[code] on the same edge that registers onehot.
REQ-019 Counters: an accepted event increments cnt of line code by 1.
REQ-020 Saturation: a counter at 2^CNT_W-1 holds its value; an event at saturation sets ovf[code].
REQ-021 Clear: a cycle with clr_req=1 zeroes pend, cnt and ovf for every line i with clr_mask[i]=1; lines with clr_mask[i]=0 are untouched.
REQ-022 Clear ack: clr_ack=1 in the cycle after each clr_req=1 cycle, including when clr_mask=0; back-to-back requests give back-to-back acks.
REQ-023 Set-wins: when an event and a clear target the same line in the same cycle, the line ends with pend=1, cnt=1 and ovf=0.
REQ-024 Disjoint simultaneity: an event and a clear on different lines in the same cycle both take effect.
REQ-025 Clear does not affect onehot or onehot_v.
REQ-026 code is don't-care when code_v=0; X on code with code_v=0 does not propagate to any output.

Reset
REQ-027 When rst=1 at a rising edge, onehot, onehot_v, pend, cnt, ovf and clr_ack are all zero after that edge.
REQ-028 rst takes priority over any concurrent event or clear; events and clears during reset are dropped.
REQ-029 Reset asserted mid-stream discards in-flight decode; the first accepted code after release decodes normally with 1-cycle latency.

Structure
REQ-030 A shared package holds the line count (4), code width (2) and the default CNT_W.
REQ-031 A sub-module dec_line_ctr holds one line's pending bit, saturating counter and ovf bit, and is instantiated four times; the decode register and clr_ack stay in the top level.

Verification
REQ-032 Reset: hold rst=1 for 2 cycles with code_v=1, code=2 -> all outputs 0 the cycle after release.
REQ-033 Stream: code 0,1,2,3 on consecutive cycles with code_v=1 -> onehot 0001,0010,0100,1000 on the next four cycles; pend=1111; each cnt=1.
REQ-034 Saturation (CNT_W=4): 17 events on line 2 -> cnt[2]=15 and ovf[2]=1; other lines 0.
REQ-035 Clear: with pend=1111, clr_req=1 and clr_mask=0101 -> pend=1010 and clr_ack=1 the next cycle; cnt of lines 0 and 2 are 0.
REQ-036 Collision: event on line 1 plus clr_req with clr_mask=0010 in the same cycle, with cnt[1]=5 beforehand -> pend[1]=1, cnt[1]=1, ovf[1]=0.
REQ-037 Mid-stream reset: rst pulsed during a 4-code stream, then code=3 -> onehot=1000 exactly one cycle later; no stale onehot_v appears.
